// File: rtl/note_recorder_if.sv
// -----------------------------------------------------------------------------
// note_recorder_if
// Write port toward the note RAM: one strobe, one address, one 15-bit note
// word {note_hz[13:0], note_pause}.
//   master : the recorder (drives wr_en/wr_addr/wr_data)
//   slave  : the RAM side (samples them)
// -----------------------------------------------------------------------------
interface note_recorder_if #(
  parameter int ADDR_W = 10
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [14:0]       wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/note_recorder.sv
// -----------------------------------------------------------------------------
// note_recorder
// Measures a square-wave tone on a fixed beat grid and writes one note word per
// beat slot into a note RAM, using the Buzzer encoding:
//   note_hz    = half-period in measurement ticks minus 1 (14'h3FFF = rest)
//   note_pause = 1 when the tone stopped before the second half of the slot
//
// Ports
//   clk      system clock
//   rst      asynchronous active-high reset
//   start    one-cycle pulse, begins a recording at address 0
//   stop     one-cycle pulse, ends the recording after the current slot
//   tone_in  asynchronous square-wave input
//   wr       note RAM write port (note_recorder_if.master)
//   busy     recording in progress (ARM or RECORD)
//   done     recording finished (DONE)
//   count    number of words written so far
//
// Build option
//   NOTE_RECORDER_ARM_EN : when defined, start first waits in ARM for the
//   first tone edge so that leading silence is not recorded.
// -----------------------------------------------------------------------------
module note_recorder #(
  parameter int TICK_DIV    = 8,
  parameter int SLOT_CYCLES = 16_666_666,
  parameter int LENGTH      = 783,
  parameter int ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              tone_in,
  note_recorder_if.master   wr,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] count
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [PW-1:0]     PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0]     SLOT_LAST  = SW'(SLOT_CYCLES - 1);
  localparam logic [SW-1:0]     SLOT_HALF  = SW'(SLOT_CYCLES / 2);
  localparam logic [ADDR_W-1:0] LEN_A      = ADDR_W'(LENGTH);
  localparam logic [13:0]       HP_MAX     = 14'h3FFF;

`ifdef NOTE_RECORDER_ARM_EN
  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RECORD, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RECORD, S_DONE} state_t;
`endif

  state_t            state_q, state_d;
  logic              s1_q, s2_q, s3_q;
  logic [PW-1:0]     presc_q, presc_d;
  logic [13:0]       hp_cnt_q, hp_cnt_d;
  logic [13:0]       meas_q, meas_d;
  logic              meas_valid_q, meas_valid_d;
  logic              prev_valid_q, prev_valid_d;
  logic [SW-1:0]     slot_cnt_q, slot_cnt_d;
  logic              any_edge_q, any_edge_d;
  logic              late_edge_q, late_edge_d;
  logic              stop_req_q, stop_req_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [14:0]       wr_data_q, wr_data_d;

  logic edge_w;
  logic tick;
  logic begin_rec;

  // Both polarities of the synchronized tone count as an edge.
  assign edge_w = s2_q ^ s3_q;

  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    hp_cnt_d     = hp_cnt_q;
    meas_d       = meas_q;
    meas_valid_d = meas_valid_q;
    prev_valid_d = prev_valid_q;
    slot_cnt_d   = slot_cnt_q;
    any_edge_d   = any_edge_q;
    late_edge_d  = late_edge_q;
    stop_req_d   = stop_req_q;
    count_d      = count_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    tick         = 1'b0;
    begin_rec    = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          begin_rec = 1'b1;
        end
      end

`ifdef NOTE_RECORDER_ARM_EN
      S_ARM: begin
        if (stop) begin
          state_d = S_DONE;
        end else if (edge_w) begin
          // The arming edge is the reference for the first half-period.
          state_d      = S_RECORD;
          presc_d      = '0;
          slot_cnt_d   = '0;
          hp_cnt_d     = '0;
          prev_valid_d = 1'b1;
        end
      end
`endif

      S_RECORD: begin
        tick       = (presc_q == PRESC_LAST);
        presc_d    = tick ? '0 : presc_q + PW'(1);
        stop_req_d = stop_req_q | stop;

        // Edge restarts the half-period count; it wins over a same-cycle tick.
        if (edge_w) begin
          if (prev_valid_q) begin
            meas_d       = hp_cnt_q;
            meas_valid_d = 1'b1;
          end
          hp_cnt_d     = '0;
          prev_valid_d = 1'b1;
        end else if (tick && hp_cnt_q != HP_MAX) begin
          hp_cnt_d = hp_cnt_q + 14'd1;
        end

        // The cycle carrying the write strobe decides whether to stop, so the
        // strobe itself is always issued while still in RECORD.
        if (wr_en_q && (count_q == LEN_A || stop_req_q || stop)) begin
          state_d = S_DONE;
        end

        if (slot_cnt_q == SLOT_LAST) begin
          // An edge on this last cycle still belongs to the ending slot, so
          // the word uses the already-updated measurement.
          slot_cnt_d = '0;
          wr_en_d    = 1'b1;
          wr_addr_d  = count_q;
          if (!(any_edge_q | edge_w) || !meas_valid_d) begin
            wr_data_d    = {HP_MAX, 1'b1};
            prev_valid_d = 1'b0;
            meas_valid_d = 1'b0;
          end else begin
            wr_data_d = {(meas_d == 14'd0) ? 14'd0 : meas_d - 14'd1,
                         ~(late_edge_q | (edge_w && slot_cnt_q >= SLOT_HALF))};
          end
          count_d     = count_q + ADDR_W'(1);
          any_edge_d  = 1'b0;
          late_edge_d = 1'b0;
        end else begin
          slot_cnt_d  = slot_cnt_q + SW'(1);
          any_edge_d  = any_edge_q | edge_w;
          late_edge_d = late_edge_q | (edge_w && slot_cnt_q >= SLOT_HALF);
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Start (re)initialises everything; a stop in the same cycle is dropped.
    if (begin_rec) begin
`ifdef NOTE_RECORDER_ARM_EN
      state_d = S_ARM;
`else
      state_d = S_RECORD;
`endif
      count_d      = '0;
      slot_cnt_d   = '0;
      presc_d      = '0;
      hp_cnt_d     = '0;
      meas_d       = '0;
      meas_valid_d = 1'b0;
      prev_valid_d = 1'b0;
      any_edge_d   = 1'b0;
      late_edge_d  = 1'b0;
      stop_req_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      presc_q      <= '0;
      hp_cnt_q     <= '0;
      meas_q       <= '0;
      meas_valid_q <= 1'b0;
      prev_valid_q <= 1'b0;
      slot_cnt_q   <= '0;
      any_edge_q   <= 1'b0;
      late_edge_q  <= 1'b0;
      stop_req_q   <= 1'b0;
      count_q      <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      s1_q         <= tone_in;
      s2_q         <= s1_q;
      s3_q         <= s2_q;
      presc_q      <= presc_d;
      hp_cnt_q     <= hp_cnt_d;
      meas_q       <= meas_d;
      meas_valid_q <= meas_valid_d;
      prev_valid_q <= prev_valid_d;
      slot_cnt_q   <= slot_cnt_d;
      any_edge_q   <= any_edge_d;
      late_edge_q  <= late_edge_d;
      stop_req_q   <= stop_req_d;
      count_q      <= count_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign wr.wr_en   = wr_en_q;
  assign wr.wr_addr = wr_addr_q;
  assign wr.wr_data = wr_data_q;
  assign count      = count_q;
  assign done       = (state_q == S_DONE);
`ifdef NOTE_RECORDER_ARM_EN
  assign busy       = (state_q == S_RECORD) || (state_q == S_ARM);
`else
  assign busy       = (state_q == S_RECORD);
`endif

endmodule
